// File: rtl/ccff_defs.sv
// Shared definitions for the ccff_chain_mux routing primitive.
// Optional feature macro: CCFF_PARITY_EN adds one even-parity LSB to the
// configuration chain and makes a commit conditional on that parity.
package ccff_defs;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2
  } ccff_state_e;

`ifdef CCFF_PARITY_EN
  localparam int PAR_OFS = 1;
`else
  localparam int PAR_OFS = 0;
`endif

  // Config bits per channel: encoded select plus one invert bit.
  function automatic int ccff_ch_w(input int num_inputs);
    return $clog2(num_inputs) + 1;
  endfunction

  // Full shadow chain length, including the parity bit when present.
  function automatic int ccff_chain_len(input int num_mux, input int num_inputs);
    return num_mux * ccff_ch_w(num_inputs) + PAR_OFS;
  endfunction

endpackage

// File: rtl/ccff_channel_mux.sv
// One routing channel: NUM_INPUTS:1 encoded mux with output invert.
// An out-of-range select yields the invert bit alone (const0/const1);
// an inactive configuration forces the output low.
module ccff_channel_mux #(
  parameter int NUM_INPUTS = 4
) (
  input  logic [NUM_INPUTS-1:0]         data,
  input  logic [$clog2(NUM_INPUTS)-1:0] sel,
  input  logic                          inv,
  input  logic                          en,
  output logic                          y
);

  localparam int SEL_W = $clog2(NUM_INPUTS);

  // Select by explicit compare so an unused encoding never indexes past data.
  always_comb begin
    y = 1'b0;
    if (en) begin
      y = inv;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (sel == i[SEL_W-1:0]) y = data[i] ^ inv;
      end
    end
  end

endmodule

// File: rtl/ccff_chain_mux.sv
// Configurable routing primitive for the CB/SB tiles. A serial shadow
// chain is loaded through ccff_head/ccff_tail, then committed atomically
// into the active configuration that drives NUM_MUX routing channels.
// Optional feature macro: CCFF_PARITY_EN (see ccff_defs).
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_EMPTY   | no bits shifted since reset or the last commit
// ST_LOADING | some, but fewer than CHAIN_LEN, bits shifted
// ST_FULL    | CHAIN_LEN bits shifted; a commit may be accepted
module ccff_chain_mux
  import ccff_defs::*;
#(
  parameter int NUM_MUX    = 2,
  parameter int NUM_INPUTS = 4
) (
  input  logic                          prog_clk,
  input  logic                          prog_reset_n,
  input  logic                          ccff_head,
  output logic                          ccff_tail,
  input  logic                          shift_en,
  input  logic                          commit,
  output logic                          cfg_full,
  output logic                          cfg_active,
  output logic                          cfg_err,
  input  logic [NUM_MUX*NUM_INPUTS-1:0] in,
  output logic [NUM_MUX-1:0]            out
);

  localparam int SEL_W     = $clog2(NUM_INPUTS);
  localparam int CH_W      = ccff_ch_w(NUM_INPUTS);
  localparam int CHAIN_LEN = ccff_chain_len(NUM_MUX, NUM_INPUTS);
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN);

  ccff_state_e          state, state_nxt;
  logic [CHAIN_LEN-1:0] shadow;
  logic [CHAIN_LEN-1:0] active;
  logic [CNT_W-1:0]     count;
  logic                 active_vld;
  logic                 err_q;
  logic                 shift_do;
  logic                 accept;
  logic                 reject;
  logic                 parity_ok;

`ifdef CCFF_PARITY_EN
  assign parity_ok = ~(^shadow);
`else
  assign parity_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) state <= ST_EMPTY;
    else               state <= state_nxt;
  end

  // Next-state: a commit always blocks the shift, so count moves by one at most.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY:   if (shift_do) state_nxt = ST_LOADING;
      ST_LOADING: if (shift_do && count == CNT_MAX - CNT_W'(1)) state_nxt = ST_FULL;
      ST_FULL:    if (accept) state_nxt = ST_EMPTY;
      default:    state_nxt = ST_EMPTY;
    endcase
  end

  // FSM outputs: commit wins over shift; only a FULL, parity-clean chain commits.
  always_comb begin
    shift_do = shift_en & ~commit;
    accept   = commit & (state == ST_FULL) & parity_ok;
    reject   = commit & ~accept;
  end

  // Saturating bit counter, cleared by an accepted commit.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n)                    count <= '0;
    else if (accept)                      count <= '0;
    else if (shift_do && count != CNT_MAX) count <= count + CNT_W'(1);
  end

  // Shadow chain keeps streaming after full so neighbours downstream still load.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n)  shadow <= '0;
    else if (shift_do)  shadow <= {shadow[CHAIN_LEN-2:0], ccff_head};
  end

  // Active configuration and status flags; cfg_err is sticky until reset.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      active     <= '0;
      active_vld <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        active     <= shadow;
        active_vld <= 1'b1;
      end
      if (reject) err_q <= 1'b1;
    end
  end

  assign ccff_tail  = shadow[CHAIN_LEN-1];
  assign cfg_full   = (state == ST_FULL);
  assign cfg_active = active_vld;
  assign cfg_err    = err_q;

  for (genvar c = 0; c < NUM_MUX; c++) begin : g_ch
    ccff_channel_mux #(
      .NUM_INPUTS(NUM_INPUTS)
    ) u_mux (
      .data (in[c*NUM_INPUTS +: NUM_INPUTS]),
      .sel  (active[PAR_OFS + c*CH_W +: SEL_W]),
      .inv  (active[PAR_OFS + c*CH_W + SEL_W]),
      .en   (active_vld),
      .y    (out[c])
    );
  end

endmodule

// File: tb/tb_ccff_chain_mux.sv
module tb_ccff_chain_mux;

  localparam int NM = 2;
  localparam int NI = 4;
  localparam int SW = 2;
  localparam int CW = 3;
`ifdef CCFF_PARITY_EN
  localparam int PO = 1;
`else
  localparam int PO = 0;
`endif
  localparam int CL  = NM*CW + PO;
  localparam int CL2 = 2*3 + PO;

  logic          prog_clk = 1'b0;
  logic          prog_reset_n = 1'b0;
  logic          ccff_head = 1'b0, shift_en = 1'b0, commit = 1'b0;
  logic [NM*NI-1:0] in_d = '0;
  logic          ccff_tail, cfg_full, cfg_active, cfg_err;
  logic [NM-1:0] out_d;

  logic          head2 = 1'b0, shift2 = 1'b0, commit2 = 1'b0;
  logic [5:0]    in2 = '0;
  logic          tail2, full2, active2, err2;
  logic [1:0]    out2;

  ccff_chain_mux #(.NUM_MUX(NM), .NUM_INPUTS(NI)) dut (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .ccff_head(ccff_head),
    .ccff_tail(ccff_tail), .shift_en(shift_en), .commit(commit),
    .cfg_full(cfg_full), .cfg_active(cfg_active), .cfg_err(cfg_err),
    .in(in_d), .out(out_d));

  ccff_chain_mux #(.NUM_MUX(2), .NUM_INPUTS(3)) dut3 (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .ccff_head(head2),
    .ccff_tail(tail2), .shift_en(shift2), .commit(commit2),
    .cfg_full(full2), .cfg_active(active2), .cfg_err(err2),
    .in(in2), .out(out2));

  always #5 prog_clk = ~prog_clk;

  typedef struct packed {
    logic [NM-1:0] out;
    logic          full;
    logic          active;
    logic          err;
    logic          tail;
  } obs_t;

  obs_t exp_q[$];
  obs_t g, e;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [CL-1:0] m_sh = '0;
  logic [CL-1:0] m_act = '0;
  int            m_cnt = 0;
  logic          m_actv = 1'b0;
  logic          m_err = 1'b0;

  function automatic logic [NM-1:0] model_out(input logic [NM*NI-1:0] d);
    logic [NM-1:0] r;
    int sel;
    logic inv;
    r = '0;
    for (int c = 0; c < NM; c++) begin
      sel = int'(m_act[PO + c*CW +: SW]);
      inv = m_act[PO + c*CW + SW];
      if (!m_actv)      r[c] = 1'b0;
      else if (sel < NI) r[c] = d[c*NI + sel] ^ inv;
      else              r[c] = inv;
    end
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t s;
    s = {out_d, cfg_full, cfg_active, cfg_err, ccff_tail};
    return s;
  endfunction

  function automatic logic [CL2-1:0] mkw2(input logic [5:0] f);
`ifdef CCFF_PARITY_EN
    return {f, ^f};
`else
    return f;
`endif
  endfunction

  task automatic model_reset();
    m_sh = '0; m_act = '0; m_cnt = 0; m_actv = 1'b0; m_err = 1'b0;
  endtask

  // Drive one cycle of stimulus on the main DUT and push the spec outcome.
  task automatic step(input logic sh, input logic cm, input logic hd,
                      input logic [NM*NI-1:0] d);
    obs_t x;
    @(negedge prog_clk);
    shift_en = sh; commit = cm; ccff_head = hd; in_d = d;
    if (cm) begin
      if (m_cnt == CL && (PO == 0 || (^m_sh) == 1'b0)) begin
        m_act = m_sh; m_actv = 1'b1; m_cnt = 0;
      end else begin
        m_err = 1'b1;
      end
    end else if (sh) begin
      m_sh = {m_sh[CL-2:0], hd};
      if (m_cnt < CL) m_cnt++;
    end
    x.out = model_out(d); x.full = (m_cnt == CL); x.active = m_actv;
    x.err = m_err; x.tail = m_sh[CL-1];
    exp_q.push_back(x);
    @(posedge prog_clk);
    #1;
    shift_en = 1'b0; commit = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge prog_clk);
    shift_en = 0; commit = 0; shift2 = 0; commit2 = 0;
    prog_reset_n = 1'b0;
    model_reset();
    #3;
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    in_d = '1; in2 = '1;
    #12;
    exp_q.push_back('0);
    g = sample(); e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL reset main: got %b expected %b", g, e); end
    n_checks++;
    if ({out2, full2, active2, err2, tail2} !== 6'b0) begin
      n_fail++; $display("FAIL reset ni3: got %b expected %b", {out2, full2, active2, err2, tail2}, 6'b0);
    end
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
  endtask

`ifdef CCFF_PARITY_EN
  task automatic test_parity();
    logic [6:0] bad, good;
    bad = 7'b1010100; good = 7'b1010101;
    for (int i = CL-1; i >= 0; i--) begin
      step(1, 0, bad[i], 8'hFF);
      g = sample(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL parity bad load %0d: got %b expected %b", i, g, e); end
    end
    step(0, 1, 0, 8'hFF);
    g = sample(); e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL parity bad commit: got %b expected %b", g, e); end
    n_checks++;
    if ({cfg_err, cfg_active, cfg_full} !== 3'b101) begin
      n_fail++; $display("FAIL parity reject flags: got %b expected 101", {cfg_err, cfg_active, cfg_full});
    end
    for (int i = CL-1; i >= 0; i--) begin
      step(1, 0, good[i], 8'hFF);
      g = sample(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL parity good load %0d: got %b expected %b", i, g, e); end
    end
    step(0, 1, 0, 8'hFF);
    g = sample(); e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL parity good commit: got %b expected %b", g, e); end
    n_checks++;
    if (cfg_active !== 1'b1) begin n_fail++; $display("FAIL parity accept: got %b expected 1", cfg_active); end
  endtask
`endif

  task automatic test_load_commit();
    logic [CL-1:0] w;
    logic [NM*NI-1:0] pats [4];
`ifdef CCFF_PARITY_EN
    w = 7'b1010101;
`else
    w = 6'b101010;
`endif
    pats[0] = 8'hFB; pats[1] = 8'h20; pats[2] = 8'hFF; pats[3] = 8'h00;
    for (int i = CL-1; i >= 0; i--) begin
      step(1, 0, w[i], 8'h04);
      g = sample(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL load bit %0d: got %b expected %b", i, g, e); end
    end
    step(0, 1, 0, 8'h04);
    g = sample(); e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL load commit: got %b expected %b", g, e); end
    n_checks++;
    if ({out_d, cfg_full, cfg_active} !== 4'b1101) begin
      n_fail++; $display("FAIL load commit out: got %b expected 1101", {out_d, cfg_full, cfg_active});
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, pats[k]);
      g = sample(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL datapath pat %0d: got %b expected %b", k, g, e); end
    end
  endtask

  task automatic test_early_commit();
    logic [NM-1:0] prev;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, (i < 2), 8'h04);
      g = sample(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL early shift %0d: got %b expected %b", i, g, e); end
    end
    prev = out_d;
    step(0, 1, 0, 8'h04);
    g = sample(); e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL early commit: got %b expected %b", g, e); end
    n_checks++;
    if ({cfg_err, out_d} !== {1'b1, prev}) begin
      n_fail++; $display("FAIL early reject: got %b expected %b", {cfg_err, out_d}, {1'b1, prev});
    end
    for (int i = 3; i < CL; i++) begin
      step(1, 0, 0, 8'h04);
      g = sample(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL early refill %0d: got %b expected %b", i, g, e); end
    end
    n_checks++;
    if (cfg_full !== 1'b1) begin n_fail++; $display("FAIL early full: got %b expected 1", cfg_full); end
  endtask

  task automatic test_collision();
    step(1, 1, 1, 8'hA5);
    g = sample(); e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL collision: got %b expected %b", g, e); end
    n_checks++;
    if ({cfg_full, cfg_active} !== 2'b01) begin
      n_fail++; $display("FAIL collision flags: got %b expected 01", {cfg_full, cfg_active});
    end
    step(1, 0, 0, 8'hA5);
    g = sample(); e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL collision next: got %b expected %b", g, e); end
  endtask

  task automatic load3(input logic [CL2-1:0] w);
    for (int i = CL2-1; i >= 0; i--) begin
      @(negedge prog_clk); shift2 = 1'b1; head2 = w[i];
      @(posedge prog_clk); #1; shift2 = 1'b0;
    end
    @(negedge prog_clk); commit2 = 1'b1;
    @(posedge prog_clk); #1; commit2 = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [1:0] exp3;
    load3(mkw2(6'b111_011));
    for (int k = 0; k < 6; k++) begin
      in2 = 6'($urandom); #1;
      exp_q.push_back({2'b10, 1'b0, 1'b1, 1'b0, 1'b1});
      e = exp_q.pop_front(); exp3 = e.out; n_checks++;
      if ({out2, active2, err2} !== {exp3, 2'b10}) begin
        n_fail++; $display("FAIL range inv0/1 in=%b: got %b expected %b", in2, {out2, active2, err2}, {exp3, 2'b10});
      end
    end
    load3(mkw2(6'b011_111));
    for (int k = 0; k < 6; k++) begin
      in2 = 6'($urandom); #1;
      exp_q.push_back({2'b01, 1'b0, 1'b1, 1'b0, 1'b0});
      e = exp_q.pop_front(); exp3 = e.out; n_checks++;
      if ({out2, active2, err2} !== {exp3, 2'b10}) begin
        n_fail++; $display("FAIL range inv1/0 in=%b: got %b expected %b", in2, {out2, active2, err2}, {exp3, 2'b10});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), 1'($urandom), 8'($urandom));
      g = sample(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL random %0d: got %b expected %b", i, g, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [CL-1:0] w;
`ifdef CCFF_PARITY_EN
    w = 7'b1010101;
`else
    w = 6'b101010;
`endif
    reset_dut();
    for (int i = CL-1; i >= 0; i--) step(1, 0, w[i], 8'h04);
    step(0, 1, 0, 8'h04);
    step(1, 0, 1, 8'h04);
    step(1, 0, 1, 8'h04);
    for (int i = 0; i < CL + 3; i++) begin
      g = sample(); e = exp_q.pop_front();
    end
    n_checks++;
    if ({out_d, cfg_active} !== 3'b111) begin
      n_fail++; $display("FAIL pre-reset out: got %b expected 111", {out_d, cfg_active});
    end
    @(negedge prog_clk);
    #2 prog_reset_n = 1'b0;
    #1;
    exp_q.push_back('0);
    g = sample(); e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL async reset: got %b expected %b", g, e); end
    model_reset();
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
`ifdef CCFF_PARITY_EN
    test_parity();
`endif
    test_load_commit();
    test_early_commit();
    test_collision();
    test_out_of_range();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ccff_chain_mux.md
Name: ccff_chain_mux

Overview:
Parametrised successor to the essential-gate set (const0/const1, INVTX1, buf4, TGATE). It is a configurable routing primitive. A configuration-chain flip-flop (ccff) shadow register is loaded serially, then committed atomically into an active configuration register. The active configuration drives NUM_MUX independent N:1 routing muxes, each with a per-channel output-invert bit. It sits in the CB/SB tiles of the eFPGA fabric and is daisy-chained head-to-tail with neighbouring instances.

Parameters:
NUM_MUX, 2, number of independent routing channels.
NUM_INPUTS, 4, inputs per channel mux (>=2).
SEL_W, derived localparam = $clog2(NUM_INPUTS), encoded select width per channel.
CH_W, derived localparam = SEL_W+1, config bits per channel ({inv, sel}).
CHAIN_LEN, derived localparam = NUM_MUX*CH_W (+1 with CCFF_PARITY_EN), shadow chain length.
CNT_W, derived localparam = $clog2(CHAIN_LEN+1), bit-counter width.

Ports:
prog_clk  input  1  programming clock; all state on rising edge.
prog_reset_n  input  1  asynchronous, active-low reset.
ccff_head  input  1  serial config data in.
ccff_tail  output  1  serial config data out; equals shadow[CHAIN_LEN-1].
shift_en  input  1  shift one bit into the chain this cycle.
commit  input  1  request copy of shadow into active config.
cfg_full  output  1  CHAIN_LEN bits shifted since last reset/commit.
cfg_active  output  1  active config is valid; at least one commit has been accepted.
cfg_err  output  1  sticky: commit rejected.
in  input  NUM_MUX*NUM_INPUTS  mux data inputs; channel c uses in[c*NUM_INPUTS +: NUM_INPUTS].
out  output  NUM_MUX  mux outputs.

Behaviour:
- Reset (async assert, sync-safe release): shadow=0, active=0, bit count=0, cfg_full=0, cfg_active=0, cfg_err=0, ccff_tail=0, out=0.
- Shift: when shift_en=1 and commit=0: shadow <= {shadow[CHAIN_LEN-2:0], ccff_head}; count <= min(count+1, CHAIN_LEN), saturating.
- Shifting continues past full: data keeps streaming to ccff_tail; cfg_full stays 1.
- cfg_full = (count==CHAIN_LEN), registered. Latency: high the cycle after the CHAIN_LEN-th shift edge.
- Channel layout: channel c config = shadow[c*CH_W +: CH_W]; bits [SEL_W-1:0]=sel, bit [SEL_W]=inv. The last bit shifted lands in channel 0, bit 0.
- Control state machine:
  - EMPTY (count=0) -> LOADING on shift.
  - LOADING -> FULL when count reaches CHAIN_LEN.
  - FULL -> EMPTY on accepted commit.
- Commit accepted only in FULL:
  - active <= shadow; cfg_active <= 1; count <= 0.
  - shadow is retained, so re-shifting partially never corrupts active.
- Commit in EMPTY/LOADING: rejected; active unchanged; cfg_err <= 1. cfg_err is cleared only by reset.
- commit and shift_en in the same cycle: commit wins; the shift is ignored (no shadow change, head bit dropped).
- Datapath (combinational from in and active):
  - out[c] = cfg_active ? (in[c*NUM_INPUTS+sel] ^ inv) : 0.
  - If sel >= NUM_INPUTS (non-power-of-2 sizes), out[c] = inv. This is const0 with optional inversion.
  - Never X/Z for a defined select.
- Reset mid-load or mid-commit: everything returns to reset values; out drops to 0 asynchronously.

Optional Feature:
CCFF_PARITY_EN
- Defined:
  - CHAIN_LEN gains one extra LSB parity bit (the last bit shifted). Channel fields shift up by one.
  - On commit in FULL, even parity over all CHAIN_LEN bits must be 0. If not, the commit is rejected: cfg_err <= 1, active unchanged, count unchanged.
- Undefined: no parity bit; commit in FULL is always accepted.

Decomposition:
- Shared package/include ccff_defs:
  - state encoding EMPTY=2'd0, LOADING=2'd1, FULL=2'd2;
  - helper function for CH_W/CHAIN_LEN;
  - the CCFF_PARITY_EN parity offset constant.
- One sub-module, ccff_channel_mux: a single channel's NUM_INPUTS:1 encoded mux with invert and out-of-range/inactive gating. It is instantiated NUM_MUX times via generate.

Test Plan:
- Reset with in=all 1s -> out=2'b00, cfg_active=0, cfg_full=0, cfg_err=0, ccff_tail=0.
- (NUM_MUX=2, NUM_INPUTS=4) shift head 1,0,1,0,1,0, then commit; in=8'b0000_0100 -> shadow=6'b101010, ch0 sel=2 inv=0, ch1 sel=1 inv=1; out=2'b11; cfg_full 1->0; cfg_active=1.
- Commit after only 3 shifts -> cfg_err=1, out unchanged from prior config, count stays 3; three more shifts -> cfg_full=1.
- FULL, assert shift_en and commit together with head=1 -> commit taken, shadow unchanged, count=0, head bit lost.
- NUM_INPUTS=3, sel=3 with inv=0 then inv=1 -> out=0, then out=1, for any in.
- CCFF_PARITY_EN: load 7 bits with odd parity, commit -> rejected, cfg_err=1, cfg_active=0; correct the parity bit, reload, commit -> accepted.
